loader_ram_arbiter: RTL and testbench

//  Shares the single-port system RAM between the cmd loader write stream and the Z80 CPU bus.

---
 rtl/loader_ram_arbiter.sv | 168 ++++++++++++++++
 tb/tb_loader_ram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loader_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : loader_ram_arbiter
// Purpose  : Shares one single-port system RAM between the command loader
//            write stream (queued in a small FIFO, served first) and the Z80
//            CPU bus (req/ack handshake). Generates loader backpressure and a
//            CPU stall that is held until a download has fully committed.
// Revision : 1.0 - initial release
// ============================================================================
module loader_ram_arbiter #(
  parameter int DATA       = 8,
  parameter int ADDR       = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_LEVEL = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ldr_wr,
  input  logic [ADDR-1:0] ldr_addr,
  input  logic [DATA-1:0] ldr_data,
  input  logic            ldr_download,
  output logic            ldr_wait,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [ADDR-1:0] cpu_addr,
  input  logic [DATA-1:0] cpu_wdata,
  output logic            cpu_ack,
  output logic [DATA-1:0] cpu_rdata,
  output logic            cpu_hold,
  output logic [ADDR-1:0] ram_addr,
  output logic [DATA-1:0] ram_wdata,
  output logic            ram_we,
  input  logic [DATA-1:0] ram_rdata,
  output logic            overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LWRITE  = 2'd1,
    S_CACCESS = 2'd2,
    S_CDONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [ADDR-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic            r_dl_prev;

  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_dl_rise;
  logic            w_grant_cpu;

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  // Popping is the same event as granting the RAM to the loader.
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push    = ldr_wr && (!w_full || w_pop);
  assign w_drop    = ldr_wr && w_full && !w_pop;
  assign w_dl_rise = ldr_download && !r_dl_prev;
  assign w_count_nxt = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};

  // A loader write arriving this very cycle also blocks the CPU grant, so the
  // loader keeps priority even when its write has not reached the FIFO yet.
  assign w_grant_cpu = (r_state == S_IDLE) && (r_count == '0) && !ldr_wr &&
                       cpu_req && !cpu_hold && !cpu_ack;

  // Next-state selection for the RAM port owner.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop)            w_state_nxt = S_LWRITE;
        else if (w_grant_cpu) w_state_nxt = S_CACCESS;
      end
      S_LWRITE:  w_state_nxt = S_IDLE;
      S_CACCESS: w_state_nxt = S_CDONE;
      S_CDONE:   w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Loader write FIFO: storage, wrapping pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_addr[r_wr_ptr] <= ldr_addr;
        r_fifo_data[r_wr_ptr] <= ldr_data;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  // Registered RAM port; address and data hold when nothing is granted.
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (w_pop) begin
        ram_addr  <= r_fifo_addr[r_rd_ptr];
        ram_wdata <= r_fifo_data[r_rd_ptr];
        ram_we    <= 1'b1;
      end else if (w_grant_cpu) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
        ram_we    <= cpu_we;
      end
    end
  end

  // CPU completion: capture RAM read data and pulse ack for one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ack <= (r_state == S_CDONE);
      if (r_state == S_CDONE) cpu_rdata <= ram_rdata;
    end
  end

  // Status flags: backpressure, sticky drop indicator and CPU stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      ldr_wait  <= 1'b0;
      overflow  <= 1'b0;
      cpu_hold  <= 1'b0;
      r_dl_prev <= 1'b0;
    end else begin
      r_dl_prev <= ldr_download;
      ldr_wait  <= (w_count_nxt >= CW'(WAIT_LEVEL));
      if (w_drop)         overflow <= 1'b1;
      else if (w_dl_rise) overflow <= 1'b0;
      if (w_dl_rise)
        cpu_hold <= 1'b1;
      else if (!ldr_download && (r_count == '0) && (r_state == S_IDLE))
        cpu_hold <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_loader_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_loader_ram_arbiter
// Purpose  : Scoreboard bench for loader_ram_arbiter with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_loader_ram_arbiter;

  localparam int DEPTH = 4;
  localparam int WLVL  = 2;

  logic        clk;
  logic        reset;
  logic        ldr_wr;
  logic [15:0] ldr_addr;
  logic [7:0]  ldr_data;
  logic        ldr_download;
  logic        ldr_wait;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_hold;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic        overflow;

  loader_ram_arbiter #(
    .DATA(8), .ADDR(16), .FIFO_DEPTH(DEPTH), .WAIT_LEVEL(WLVL)
  ) dut (
    .clock(clk), .reset(reset),
    .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_data(ldr_data),
    .ldr_download(ldr_download), .ldr_wait(ldr_wait),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic we; logic [7:0] d; } rd_t;

  logic [7:0] mem     [65536];
  logic [7:0] ref_mem [65536];
  wr_t        exp_wr[$];
  rd_t        exp_rd[$];
  int         checks = 0;
  int         errors = 0;
  bit         ref_ovf = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endfunction

  // Synchronous RAM, one cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Monitor: pops the scoreboard whenever the DUT writes RAM or acks the CPU.
  wr_t ew;
  rd_t er;
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_we) begin
        if (exp_wr.size() == 0) begin
          chk("ram_we_unexpected", 32'(ram_we), 32'd0);
        end else begin
          ew = exp_wr.pop_front();
          chk("ram_write_addr", 32'(ram_addr), 32'(ew.a));
          chk("ram_write_data", 32'(ram_wdata), 32'(ew.d));
        end
      end
      if (cpu_ack) begin
        if (exp_rd.size() == 0) begin
          chk("cpu_ack_unexpected", 32'(cpu_ack), 32'd0);
        end else begin
          er = exp_rd.pop_front();
          if (!er.we) chk("cpu_rdata", 32'(cpu_rdata), 32'(er.d));
        end
      end
    end
  end

  // Loader burst on consecutive cycles starting from an empty, idle arbiter.
  // The drain rate is one write per two cycles, so occupancy after write k is
  // min(ceil((k+1)/2), DEPTH); once full, every even-indexed write is lost.
  task automatic burst(input int n, input logic [15:0] base, input bit fixed,
                       output bit dropped);
    logic [7:0] d;
    int occ;
    dropped = 0;
    for (int k = 0; k < n; k++) begin
      d = fixed ? 8'(8'hAA + 8'h11 * k) : 8'($urandom);
      ldr_wr   = 1'b1;
      ldr_addr = base + 16'(k);
      ldr_data = d;
      if (k < 2 * DEPTH || (k % 2) == 1) begin
        exp_wr.push_back('{a: base + 16'(k), d: d});
        ref_mem[base + 16'(k)] = d;
      end else begin
        dropped = 1;
      end
      @(posedge clk); #1;
      occ = (k + 2) / 2;
      if (occ > DEPTH) occ = DEPTH;
      chk("ldr_wait", 32'(ldr_wait), 32'(occ >= WLVL));
    end
    ldr_wr = 1'b0;
    if (dropped) ref_ovf = 1;
  endtask

  task automatic cpu_access(input bit we, input logic [15:0] a, input logic [7:0] d,
                            output int lat);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    exp_rd.push_back('{we: we, d: ref_mem[a]});
    if (we) begin
      exp_wr.push_back('{a: a, d: d});
      ref_mem[a] = d;
    end
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (cpu_ack) break;
      if (lat >= 200) begin fail_now("cpu_ack_timeout"); break; end
    end
    cpu_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0 || ldr_wait) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) fail_now("drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit dropped;
    int lat;
    int op;
    int hold_bad;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'(i) ^ 8'(i >> 8);
      ref_mem[i] = 8'(i) ^ 8'(i >> 8);
    end
    reset = 1'b1; ldr_wr = 0; ldr_addr = 0; ldr_data = 0; ldr_download = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_ldr_wait", 32'(ldr_wait), 0);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_cpu_hold", 32'(cpu_hold), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_overflow", 32'(overflow), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Three consecutive loader writes.
    burst(3, 16'h4200, 1, dropped);
    wait_idle();
    chk("t1_overflow", 32'(overflow), 0);

    // Long burst overruns the FIFO; a download rise clears the flag.
    burst(10, 16'h5000, 0, dropped);
    wait_idle();
    chk("t2_overflow_set", 32'(overflow), 1);
    ldr_download = 1'b1;
    @(posedge clk); #1;
    chk("t2_overflow_clr", 32'(overflow), 0);
    chk("t2_hold_set", 32'(cpu_hold), 1);
    ref_ovf = 0;
    ldr_download = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("t2_hold_clr", 32'(cpu_hold), 0);

    // Uncontended CPU read.
    mem[16'h3C00] = 8'h41; ref_mem[16'h3C00] = 8'h41;
    fork
      cpu_access(0, 16'h3C00, 8'h00, lat);
      begin
        @(posedge clk); #1;
        chk("t3_ram_addr", 32'(ram_addr), 32'h3C00);
        chk("t3_ram_we", 32'(ram_we), 0);
      end
    join
    chk("t3_latency", 32'(lat), 3);
    @(posedge clk); #1;
    chk("t3_single_ack", 32'(cpu_ack), 0);
    wait_idle();

    // CPU request collides with a loader write: loader goes first.
    fork
      cpu_access(0, 16'h3C00, 8'h00, lat);
      burst(1, 16'h6000, 0, dropped);
    join
    chk("t4_cpu_delayed", 32'(lat > 3), 1);
    wait_idle();

    // Download rise with writes queued and CPU waiting.
    hold_bad = 0;
    ldr_download = 1'b1;
    fork
      burst(2, 16'h7000, 0, dropped);
      cpu_access(0, 16'h1234, 8'h00, lat);
      begin
        repeat (20) begin
          @(posedge clk); #1;
          if (!cpu_hold || cpu_ack) hold_bad++;
        end
        ldr_download = 1'b0;
      end
    join
    chk("t5_hold_during_download", 32'(hold_bad), 0);
    chk("t5_cpu_after_download", 32'(lat > 20), 1);
    chk("t5_hold_released", 32'(cpu_hold), 0);
    wait_idle();

    // Randomised mix of bursts, CPU accesses and download pulses.
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: burst($urandom_range(1, 12), 16'($urandom), 0, dropped);
        1: cpu_access(0, 16'($urandom_range(16'h4200, 16'h4210)), 8'h00, lat);
        2: cpu_access(1, 16'($urandom_range(16'h4200, 16'h4210)), 8'($urandom), lat);
        default: begin
          ldr_download = 1'b1;
          @(posedge clk); #1;
          ldr_download = 1'b0;
          ref_ovf = 0;
        end
      endcase
      wait_idle();
      chk("rnd_overflow", 32'(overflow), 32'(ref_ovf));
      chk("rnd_hold", 32'(cpu_hold), 0);
    end

    // Reset with a CPU access in flight and the FIFO non-empty.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000;
    @(posedge clk); #1;
    ldr_wr = 1'b1; ldr_addr = 16'h2100; ldr_data = 8'h5A;
    @(posedge clk); #1;
    ldr_wr = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    chk("t6_cpu_ack", 32'(cpu_ack), 0);
    chk("t6_ram_we", 32'(ram_we), 0);
    chk("t6_ram_addr", 32'(ram_addr), 0);
    chk("t6_ram_wdata", 32'(ram_wdata), 0);
    chk("t6_cpu_rdata", 32'(cpu_rdata), 0);
    chk("t6_ldr_wait", 32'(ldr_wait), 0);
    reset = 1'b0;
    hold_bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ram_we || cpu_ack) hold_bad++;
    end
    chk("t6_quiet_after_reset", 32'(hold_bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
